// File: rtl/calc_pkg.sv
// Shared types for the calculator controller: opcodes, FSM states, default width.
// The build option CALC_ACUMULADOR_EN decides which opcodes are supported.
package calc_pkg;

  localparam int CALC_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_SOMA     = 2'b00,
    OP_SUB      = 2'b01,
    OP_ACC_SOMA = 2'b10,
    OP_ACC_SUB  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CARGA = 2'b01,
    EXEC  = 2'b10,
    FIM   = 2'b11
  } state_t;

  // Accumulator opcodes only count as supported when the accumulator path is built.
  function automatic logic op_supported(input op_t op);
`ifdef CALC_ACUMULADOR_EN
    return op inside {OP_SOMA, OP_SUB, OP_ACC_SOMA, OP_ACC_SUB};
`else
    return op inside {OP_SOMA, OP_SUB};
`endif
  endfunction

endpackage

// File: rtl/ula_calc.sv
// Combinational add/subtract unit; carry is the sum carry-out or the subtract borrow.
// Outputs are forced to zero while enable is low.
module ula_calc
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  input  logic             enable,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    if (enable) begin
      case (op)
        OP_SOMA, OP_ACC_SOMA: {carry, result} = {1'b0, a} + {1'b0, b};
        OP_SUB, OP_ACC_SUB:   {carry, result} = {1'b0, a} - {1'b0, b};
        default:              {carry, result} = '0;
      endcase
    end
  end

endmodule

// File: rtl/controle_calc.sv
// Four-state calculator controller (IDLE -> CARGA -> EXEC -> FIM) around ula_calc.
// Define CALC_ACUMULADOR_EN to build the ACC_SOMA / ACC_SUB path (held S as operand A).
module controle_calc
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             carry,
  output logic             zero,
  output logic             erro,
  output logic             busy,
  output logic             done,
  output state_t           fsm_state
);

  // Handshake: start is only looked at in IDLE; busy covers CARGA/EXEC/FIM and
  // done is high for the single FIM cycle, when S and the flags are already valid.

  state_t           state, next_state;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] alu_a, alu_result;
  logic             alu_carry, alu_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    alu_en     = 1'b0;
    case (state)
      IDLE:  if (start) next_state = CARGA;
      CARGA: next_state = EXEC;
      EXEC: begin
        alu_en     = 1'b1;
        next_state = FIM;
      end
      FIM:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= OP_SOMA;
      a_q  <= '0;
      b_q  <= '0;
    end else if (state == CARGA) begin
      op_q <= op_t'(op);
      a_q  <= A;
      b_q  <= B;
    end
  end

`ifdef CALC_ACUMULADOR_EN
  assign alu_a = (op_q == OP_ACC_SOMA || op_q == OP_ACC_SUB) ? S : a_q;
`else
  assign alu_a = a_q;
`endif

  ula_calc #(.WIDTH(WIDTH)) u_ula (
    .a      (alu_a),
    .b      (b_q),
    .op     (op_q),
    .enable (alu_en),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Unsupported opcodes keep S, clear carry and re-derive zero from the held S.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S     <= '0;
      carry <= 1'b0;
      zero  <= 1'b1;
      erro  <= 1'b0;
    end else if (alu_en) begin
      if (op_supported(op_q)) begin
        S     <= alu_result;
        carry <= alu_carry;
        zero  <= (alu_result == '0);
        erro  <= 1'b0;
      end else begin
        carry <= 1'b0;
        zero  <= (S == '0);
        erro  <= 1'b1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == FIM);
  assign fsm_state = state;

endmodule

// File: tb/tb_controle_calc.sv
// Self-checking bench for controle_calc: directed cases, randomized operations
// against an arithmetic reference model, start-while-busy, held start and mid-op reset.
module tb_controle_calc;
  import calc_pkg::*;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b, s;
  logic         carry, zero, erro, busy, done;
  state_t       fsm_state;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  // Reference model state: held result and flags after the last operation.
  int m_s = 0, m_c = 0, m_z = 1, m_e = 0;
  logic [W-1:0] exp_q[$];

  controle_calc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .A         (a),
    .B         (b),
    .S         (s),
    .carry     (carry),
    .zero      (zero),
    .erro      (erro),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int o, input int av, input int bv);
    int x, r;
    bit sup;
`ifdef CALC_ACUMULADOR_EN
    sup = 1'b1;
`else
    sup = (o < 2);
`endif
    if (!sup) begin
      m_e = 1; m_c = 0; m_z = (m_s == 0) ? 1 : 0;
      return;
    end
    x = (o >= 2) ? m_s : av;
    if (o % 2 == 0) begin
      r = x + bv;
      m_c = (r >= MOD) ? 1 : 0;
      m_s = r % MOD;
    end else begin
      r = x - bv;
      m_c = (r < 0) ? 1 : 0;
      m_s = (r < 0) ? r + MOD : r;
    end
    m_z = (m_s == 0) ? 1 : 0;
    m_e = 0;
  endfunction

  // Called and returns at a falling edge. restart pulses start during CARGA and EXEC.
  task automatic run_op(input int o, input int av, input int bv, input bit restart);
    int dc0;
    logic [W-1:0] want;
    op = 2'(o); a = W'(av); b = W'(bv); start = 1'b1;
    model(o, av, bv);
    exp_q.push_back(W'(m_s));
    dc0 = done_cnt;
    @(negedge clk);  // CARGA
    check("busy_carga", busy, 1);
    check("done_carga", done, 0);
    start = restart;
    @(negedge clk);  // EXEC: scramble inputs, they must not matter now
    check("done_exec", done, 0);
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    start = restart;
    @(negedge clk);  // FIM
    start = 1'b0;
    want = exp_q.pop_front();
    check("done_fim", done, 1);
    check("s_fim", s, want);
    check("carry_fim", carry, m_c);
    check("zero_fim", zero, m_z);
    check("erro_fim", erro, m_e);
    @(negedge clk);  // IDLE
    check("done_idle", done, 0);
    check("busy_idle", busy, 0);
    check("s_held", s, m_s);
    @(negedge clk);
    check("no_queue_busy", busy, 0);
    check("done_count", done_cnt - dc0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_s", s, 0);
    check("rst_zero", zero, 1);
    check("rst_carry", carry, 0);
    check("rst_erro", erro, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", fsm_state, IDLE);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 100, 50, 0);  check("soma_100_50", s, 150);  check("soma_100_50_c", carry, 0);
    run_op(0, 200, 100, 0); check("soma_200_100", s, 44);  check("soma_200_100_c", carry, 1);
    run_op(1, 5, 7, 0);     check("sub_5_7", s, 254);      check("sub_5_7_c", carry, 1);
    run_op(1, 9, 9, 0);     check("sub_9_9", s, 0);        check("sub_9_9_z", zero, 1);
    run_op(0, 33, 44, 1);   check("restart_s", s, 77);

`ifdef CALC_ACUMULADOR_EN
    run_op(0, 10, 5, 0);  check("acc_base", s, 15);
    run_op(2, 99, 20, 0); check("acc_soma", s, 35);
    run_op(3, 77, 40, 0); check("acc_sub", s, 251); check("acc_sub_c", carry, 1);
`else
    run_op(0, 10, 5, 0);  check("unsup_base", s, 15);
    run_op(2, 99, 20, 0); check("unsup_s", s, 15); check("unsup_erro", erro, 1);
    check("unsup_carry", carry, 0);
`endif

    for (int i = 0; i < 30; i++)
      run_op($urandom_range(0, 3), $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), 1'($urandom));

    // start held high: a new operation every four cycles
    op = 2'b00; a = 8'd1; b = 8'd2; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("hold_done", done, (i % 4 == 2) ? 1 : 0);
      if (i == 7) start = 1'b0;
    end
    model(0, 1, 2);
    model(0, 1, 2);
    repeat (4) @(negedge clk);
    check("hold_s", s, m_s);
    check("hold_idle", busy, 0);

    // reset in the middle of EXEC
    begin
      int dc0;
      op = 2'b00; a = 8'd7; b = 8'd8; start = 1'b1;
      dc0 = done_cnt;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      check("pre_rst_state", fsm_state, EXEC);
      rst = 1'b1;
      #1;
      check("midrst_s", s, 0);
      check("midrst_zero", zero, 1);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      m_s = 0; m_c = 0; m_z = 1; m_e = 0;
      @(negedge clk); rst = 1'b0;
      repeat (4) @(negedge clk);
      check("midrst_no_done", done_cnt - dc0, 0);
      check("midrst_s_after", s, 0);
    end

    run_op(1, 3, 1, 0); check("post_rst_sub", s, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
